// File: rtl/dtc_pkg.sv
// Shared types and helpers for the DTC classifier-vote blocks.
package dtc_pkg;

    localparam int NUM_CLASSES = 9;
    localparam int THERM_W     = 8;
    localparam int CLASS_W     = 4;
    localparam int VOTE_W      = 8;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_ARG   = 2'd1,
        ST_EMIT  = 2'd2
    } state_e;

    typedef logic [VOTE_W-1:0]            vote_t;
    typedef vote_t [NUM_CLASSES-1:0]      votes_t;

    typedef struct packed {
        logic [CLASS_W-1:0] cls;
        vote_t              conf;
    } argmax_t;

    // Strict '>' keeps the earliest index on ties; all-zero votes yield class 0.
    function automatic argmax_t vote_argmax(input votes_t v);
        argmax_t r;
        r.cls  = '0;
        r.conf = v[0];
        for (int i = 1; i < NUM_CLASSES; i++) begin
            if (v[i] > r.conf) begin
                r.cls  = CLASS_W'(i);
                r.conf = v[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dtc_therm_decode.sv
// Thermometer-code decoder: legal iff the code is an LSB-aligned run of ones.
module dtc_therm_decode
    import dtc_pkg::*;
(
    input  logic [THERM_W-1:0] therm_i,
    output logic               legal_o,
    output logic [CLASS_W-1:0] class_o
);

    logic [THERM_W:0] ext;
    logic [CLASS_W-1:0] ones;

    // A run of ones from bit 0 plus one carries out cleanly, leaving no overlap.
    assign ext     = {1'b0, therm_i};
    assign legal_o = (((ext + 1'b1) & ext) == '0);

    always_comb begin
        ones = '0;
        for (int i = 0; i < THERM_W; i++) begin
            ones = ones + CLASS_W'(therm_i[i]);
        end
    end

    assign class_o = legal_o ? ones : '0;

endmodule

// File: rtl/dtc_vote_accum.sv
// Accumulates classifier votes over a window and emits the majority class.
module dtc_vote_accum
    import dtc_pkg::*;
#(
    parameter int WIN   = 8,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [THERM_W-1:0]  in_therm,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CLASS_W-1:0]  out_class,
    output logic [CNT_W-1:0]    out_conf,
    output logic                out_err
);

    localparam logic [VOTE_W-1:0] WIN_N = VOTE_W'(WIN);

    state_e             state_q, state_d;
    votes_t             votes_q, votes_d;
    logic [VOTE_W-1:0]  n_q, n_d;
    logic               err_q, err_d;
    logic [CLASS_W-1:0] class_q, class_d;
    logic [CNT_W-1:0]   conf_q, conf_d;
    logic               oerr_q, oerr_d;

    logic               legal;
    logic [CLASS_W-1:0] cls;
    logic               accept;
    argmax_t            am;

    dtc_therm_decode u_dec (
        .therm_i (in_therm),
        .legal_o (legal),
        .class_o (cls)
    );

    assign am = vote_argmax(votes_q);

    always_comb begin
        state_d   = state_q;
        votes_d   = votes_q;
        n_d       = n_q;
        err_d     = err_q;
        class_d   = class_q;
        conf_d    = conf_q;
        oerr_d    = oerr_q;
        in_ready  = (state_q == ST_ACCUM);
        out_valid = (state_q == ST_EMIT);
        accept    = in_valid && in_ready;

        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    n_d = n_q + 8'd1;
                    if (!legal) begin
                        err_d = 1'b1;
                    end else if (votes_q[cls] != '1) begin
                        votes_d[cls] = votes_q[cls] + 8'd1;
                    end
                end
                // A flush counts a sample accepted on the same edge toward n>0.
                if ((accept && (n_q + 8'd1 == WIN_N)) ||
                    (flush && ((n_q != '0) || accept))) begin
                    state_d = ST_ARG;
                end
            end
            ST_ARG: begin
                class_d = am.cls;
                conf_d  = CNT_W'(am.conf);
                oerr_d  = err_q;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (out_ready) begin
                    votes_d = '0;
                    n_d     = '0;
                    err_d   = 1'b0;
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            votes_q <= '0;
            n_q     <= '0;
            err_q   <= 1'b0;
            class_q <= '0;
            conf_q  <= '0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            votes_q <= votes_d;
            n_q     <= n_d;
            err_q   <= err_d;
            class_q <= class_d;
            conf_q  <= conf_d;
            oerr_q  <= oerr_d;
        end
    end

    assign out_class = class_q;
    assign out_conf  = conf_q;
    assign out_err   = oerr_q;

endmodule

// File: tb/tb_dtc_vote_accum.sv
// Directed bench for dtc_vote_accum with hand-computed window results.
module tb_dtc_vote_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_therm;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_class;
    logic [7:0] out_conf;
    logic       out_err;

    int checks = 0;
    int errors = 0;

    dtc_vote_accum #(.WIN(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_therm  (in_therm),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_conf  (out_conf),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] t);
        in_valid = 1'b1;
        in_therm = t;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Called right after the window-closing edge: ARG cycle, then EMIT.
    task automatic expect_result(input string tag, input logic [3:0] c,
                                 input logic [7:0] f, input logic e);
        chk({tag, "_arg_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_arg_ready"}, 32'(in_ready), 32'd0);
        tick();
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_class"}, 32'(out_class), 32'(c));
        chk({tag, "_conf"},  32'(out_conf),  32'(f));
        chk({tag, "_err"},   32'(out_err),   32'(e));
    endtask

    task automatic ack(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_ack_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_ack_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] seq32 [8];
        seq32 = '{8'h1F, 8'h1F, 8'h07, 8'h07, 8'h7F, 8'h7F, 8'h7F, 8'h07};

        rst_n = 1'b0; in_valid = 1'b0; in_therm = '0; flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_class", 32'(out_class), 32'd0);
        chk("rst_conf",  32'(out_conf),  32'd0);
        chk("rst_err",   32'(out_err),   32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", 32'(in_ready), 32'd1);

        // Eight identical class-5 samples.
        for (int i = 0; i < 8; i++) push(8'h1F);
        expect_result("w5", 4'd5, 8'd8, 1'b0);
        ack("w5");
        chk("w5_hold_class", 32'(out_class), 32'd5);
        chk("w5_hold_conf",  32'(out_conf),  32'd8);

        // 3 and 7 tie at 3 votes; lowest index wins.
        for (int i = 0; i < 8; i++) push(seq32[i]);
        expect_result("tie", 4'd3, 8'd3, 1'b0);
        ack("tie");

        // Early close via flush with one malformed code.
        for (int i = 0; i < 3; i++) push(8'h0F);
        push(8'h2D);
        chk("fl_pre_ready", 32'(in_ready), 32'd1);
        do_flush();
        expect_result("fl", 4'd4, 8'd3, 1'b1);

        // Backpressure in EMIT: nothing accepted, outputs stable, flush ignored.
        in_valid = 1'b1; in_therm = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            flush = (i == 4);
            tick();
            chk("bp_ready", 32'(in_ready),  32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_class", 32'(out_class), 32'd4);
            chk("bp_conf",  32'(out_conf),  32'd3);
        end
        flush = 1'b0; in_valid = 1'b0;
        ack("bp");

        // Next window must start at n=0: seven samples do not close it.
        for (int i = 0; i < 7; i++) push(8'h03);
        chk("n0_open_ready", 32'(in_ready), 32'd1);
        chk("n0_open_valid", 32'(out_valid), 32'd0);
        push(8'h03);
        expect_result("n0", 4'd2, 8'd8, 1'b0);
        ack("n0");

        // Reset mid-window discards the partial result.
        for (int i = 0; i < 5; i++) push(8'h07);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_class", 32'(out_class), 32'd0);
        chk("mrst_conf",  32'(out_conf),  32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("mrst_post_valid", 32'(out_valid), 32'd0);
        chk("mrst_post_ready", 32'(in_ready),  32'd1);
        for (int i = 0; i < 8; i++) push(8'h07);
        expect_result("mrst", 4'd3, 8'd8, 1'b0);
        ack("mrst");

        // Flush on an empty window is ignored.
        do_flush();
        for (int i = 0; i < 3; i++) begin
            chk("fl0_ready", 32'(in_ready),  32'd1);
            chk("fl0_valid", 32'(out_valid), 32'd0);
            tick();
        end

        // Flush together with the first sample closes a one-sample window.
        in_valid = 1'b1; in_therm = 8'hFF; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        expect_result("one", 4'd8, 8'd1, 1'b0);
        ack("one");

        // All-malformed window reports class 0 with zero confidence.
        push(8'h05);
        push(8'h80);
        do_flush();
        expect_result("ill", 4'd0, 8'd0, 1'b1);
        ack("ill");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
